// File: rtl/half_sum_sched.sv
// half_sum_sched: round-robin scheduler sharing one fp16 reduction tree among requesters
module half_sum_sched #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 10,
    parameter int LATENCY    = $clog2(WIDTH),
    parameter int FIFO_DEPTH = 8,
    parameter int IDW        = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH*16-1:0]  req_vec,
    output logic                      tree_in_valid,
    output logic [WIDTH*16-1:0]       tree_vector,
    input  logic                      tree_out_valid,
    input  logic [15:0]               tree_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [15:0]               rsp_sum,
    output logic                      busy,
    output logic                      err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int VW = WIDTH * 16;

    logic [IDW-1:0]  ptr, grant, idx, issue_id;
    logic            found, hs, pop, push;
    logic [CW-1:0]   inflight, count, used;
    logic            tag_v  [LATENCY];
    logic [IDW-1:0]  tag_id [LATENCY];
    logic [IDW+15:0] mem    [FIFO_DEPTH];
    logic [AW-1:0]   rd, wr;

    // A pop in the same cycle frees its slot, so a full FIFO can still accept an issue.
    assign push      = tag_v[LATENCY-1];
    assign rsp_valid = count != '0;
    assign pop       = rsp_valid & rsp_ready;
    assign used      = count + inflight - CW'(pop);
    assign hs        = found & rstn & (used < CW'(FIFO_DEPTH));
    assign req_ready = hs ? (NREQ'(1) << grant) : '0;
    assign busy      = (inflight != '0) | rsp_valid;
    assign {rsp_id, rsp_sum} = rsp_valid ? mem[rd] : '0;

    // Round-robin search from ptr; scanning offsets downward lets the nearest valid win.
    always_comb begin
        grant = ptr;
        idx   = '0;
        found = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = IDW'((int'(ptr) + j) % NREQ);
            if (req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Register the granted vector into the tree and advance the pointer past the winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr           <= '0;
            issue_id      <= '0;
            tree_in_valid <= 1'b0;
            tree_vector   <= '0;
        end else begin
            tree_in_valid <= hs;
            if (hs) begin
                ptr         <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                issue_id    <= grant;
                tree_vector <= req_vec[int'(grant)*VW +: VW];
            end
        end
    end

    // Requester ids travel alongside the tree so each result keeps its owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= tree_in_valid;
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Occupancy, FIFO pointers and the sticky tag/valid mismatch flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
            count    <= '0;
            rd       <= '0;
            wr       <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight + CW'(hs) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
            err      <= err | (push != tree_out_valid);
            if (push) wr <= (wr == AW'(FIFO_DEPTH - 1)) ? '0 : wr + 1'b1;
            if (pop) rd <= (rd == AW'(FIFO_DEPTH - 1)) ? '0 : rd + 1'b1;
        end
    end

    // Result storage; contents need no reset because the outputs are gated by rsp_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= {tag_id[LATENCY-1], tree_c};
    end
endmodule

// File: tb/tb_half_sum_sched.sv
// tb_half_sum_sched: randomized self-checking bench for half_sum_sched with a behavioural tree
module tb_half_sum_sched;
    localparam int NREQ = 4, WIDTH = 10, LAT = 4, DEPTH = 8, IDW = 2;

    logic clk = 1'b0, rstn = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*WIDTH*16-1:0] req_vec = '0;
    logic tree_in_valid, tree_out_valid;
    logic [WIDTH*16-1:0] tree_vector;
    logic [15:0] tree_c;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [15:0] rsp_sum;
    logic busy, err;
    logic force_ov = 1'b0;
    logic mon_en = 1'b0;
    int elem [NREQ][WIDTH];
    int n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;

    half_sum_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
        .tree_in_valid(tree_in_valid), .tree_vector(tree_vector), .tree_out_valid(tree_out_valid),
        .tree_c(tree_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .busy(busy), .err(err));

    // Small non-negative integers encoded as fp16 keep every sum exact.
    function automatic logic [15:0] i2h(input int n);
        int p = 0;
        if (n == 0) return 16'h0000;
        for (int b = 0; b < 16; b++) if ((n >> b) != 0) p = b;
        return {1'b0, 5'(p + 15), 10'((n << (10 - p)) & 1023)};
    endfunction

    function automatic int h2i(input logic [15:0] h);
        if (h[14:0] == 15'd0) return 0;
        return (1024 + int'(h[9:0])) >> (25 - int'(h[14:10]));
    endfunction

    function automatic int vsum(input logic [WIDTH*16-1:0] v);
        int s = 0;
        for (int e = 0; e < WIDTH; e++) s += h2i(v[e*16 +: 16]);
        return s;
    endfunction

    function automatic int esum(input int r);
        int s = 0;
        for (int e = 0; e < WIDTH; e++) s += elem[r][e];
        return s;
    endfunction

    // Behavioural tree: LAT-stage pipeline of {valid, fp16 sum}, reset with the block.
    logic tv [LAT];
    logic [15:0] ts [LAT];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                tv[i] <= 1'b0;
                ts[i] <= '0;
            end
        end else begin
            tv[0] <= tree_in_valid;
            ts[0] <= i2h(vsum(tree_vector));
            for (int i = 1; i < LAT; i++) begin
                tv[i] <= tv[i-1];
                ts[i] <= ts[i-1];
            end
        end
    end
    assign tree_out_valid = tv[LAT-1] | force_ov;
    assign tree_c = ts[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: outstanding results in issue order, each with its handshake edge.
    typedef struct {
        int id;
        logic [15:0] sum;
        int e;
    } ent_t;
    ent_t q[$];
    ent_t m_n;
    int mptr = 0, m_g;
    logic m_ev, m_ep;
    logic [NREQ-1:0] m_er;

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            mptr = 0;
        end else if (mon_en) begin
            m_ev = (q.size() > 0) && (q[0].e + LAT + 1 <= cyc);
            n_vec++;
            if (rsp_valid !== m_ev) begin
                n_err++;
                $display("FAIL mon_rsp_valid @%0t: got %b want %b", $time, rsp_valid, m_ev);
            end
            if (m_ev) begin
                n_vec++;
                if (rsp_id !== IDW'(q[0].id) || rsp_sum !== q[0].sum) begin
                    n_err++;
                    $display("FAIL mon_rsp_data @%0t: got id %0d sum %h want id %0d sum %h",
                             $time, rsp_id, rsp_sum, q[0].id, q[0].sum);
                end
            end
            n_vec++;
            if (busy !== (q.size() > 0)) begin
                n_err++;
                $display("FAIL mon_busy @%0t: got %b want %b", $time, busy, q.size() > 0);
            end
            m_ep = m_ev & rsp_ready;
            m_g = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (req_valid[(mptr + j) % NREQ]) begin
                    m_g = (mptr + j) % NREQ;
                    break;
                end
            end
            m_er = (m_g >= 0 && q.size() - int'(m_ep) < DEPTH) ? (NREQ'(1) << m_g) : '0;
            n_vec++;
            if (req_ready !== m_er) begin
                n_err++;
                $display("FAIL mon_req_ready @%0t: got %b want %b", $time, req_ready, m_er);
            end
            if (m_ep) void'(q.pop_front());
            if (m_er != '0) begin
                m_n.id = m_g;
                m_n.sum = i2h(esum(m_g));
                m_n.e = cyc + 1;
                q.push_back(m_n);
                mptr = (m_g + 1) % NREQ;
            end
        end
    end

    task automatic randomize_vecs();
        for (int r = 0; r < NREQ; r++)
            for (int e = 0; e < WIDTH; e++) begin
                elem[r][e] = $urandom_range(0, 7);
                req_vec[(r*WIDTH + e)*16 +: 16] = i2h(elem[r][e]);
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        force_ov = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain();
        logic ok = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL drain_timeout: busy still %b, want 0", busy);
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        #1 rstn = 1'b0;
        #1;
        n_vec += 8;
        if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        if (tree_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_tree_in_valid: got %b want 0", tree_in_valid); end
        if (tree_vector !== '0) begin n_err++; $display("FAIL reset_tree_vector: got %h want 0", tree_vector); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        if (rsp_sum !== '0) begin n_err++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        @(posedge clk); #1;
        req_valid = '0;
        rstn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== '0) begin n_err++; $display("FAIL idle_req_ready: got %b want 0", req_ready); end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        for (int e = 0; e < WIDTH; e++) begin
            elem[0][e] = 1;
            req_vec[e*16 +: 16] = 16'h3C00;
        end
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_rsp: cycle %0d got %b want 0", i, rsp_valid); end
        end
        @(negedge clk);
        n_vec += 3;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
        if (rsp_sum !== 16'h4900) begin n_err++; $display("FAIL single_rsp_sum: got %h want 4900", rsp_sum); end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int npop = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            req_valid = (i < 12) ? '1 : '0;
            randomize_vecs();
            @(negedge clk);
            if (i < 12) begin
                n_vec++;
                if (req_ready !== (NREQ'(1) << (i % NREQ))) begin
                    n_err++;
                    $display("FAIL rr_grant: step %0d got %b want %b", i, req_ready, NREQ'(1) << (i % NREQ));
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                if (rsp_id !== IDW'(npop % NREQ)) begin
                    n_err++;
                    $display("FAIL rr_rsp_id: result %0d got %0d want %0d", npop, rsp_id, npop % NREQ);
                end
                npop++;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (npop != 12) begin n_err++; $display("FAIL rr_result_count: got %0d want 12", npop); end
    endtask

    task automatic test_backpressure();
        int nhs = 0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 20; i++) begin
            randomize_vecs();
            @(negedge clk);
            nhs += $countones(req_ready);
            @(posedge clk); #1;
        end
        n_vec++;
        if (nhs != DEPTH) begin n_err++; $display("FAIL bp_handshakes: got %0d want %0d", nhs, DEPTH); end
        @(negedge clk);
        n_vec += 2;
        if (req_ready !== '0) begin n_err++; $display("FAIL bp_stalled: got %b want 0", req_ready); end
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_vec += 2;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(i % NREQ)) begin
                n_err++;
                $display("FAIL bp_pop_order: pop %0d got valid %b id %0d want 1/%0d", i, rsp_valid, rsp_id, i % NREQ);
            end
            if (req_ready === '0) begin n_err++; $display("FAIL bp_resume: pop %0d got %b want nonzero", i, req_ready); end
            @(posedge clk); #1;
            randomize_vecs();
        end
        drain();
    endtask

    task automatic test_simultaneous();
        int npop = 0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (16) begin
            randomize_vecs();
            @(posedge clk); #1;
        end
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec += 2;
        if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sim_grant: got %b want 0100", req_ready); end
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sim_rsp_valid: got %b want 1", rsp_valid); end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 req_valid = '1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== '0) begin n_err++; $display("FAIL sim_full_again: got %b want 0", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) npop++;
        end
        n_vec++;
        if (npop != DEPTH) begin n_err++; $display("FAIL sim_fifo_count: got %0d want %0d", npop, DEPTH); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (3) begin
            randomize_vecs();
            @(posedge clk); #1;
        end
        req_valid = '0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rstn = 1'b0;
        #1;
        n_vec += 4;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b want 0", err); end
        if (tree_in_valid !== 1'b0) begin n_err++; $display("FAIL mid_tree_in_valid: got %b want 0", tree_in_valid); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_lowest_grant: got %b want 0010", req_ready); end
        drain();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL mid_err_after: got %b want 0", err); end
    endtask

    task automatic test_mismatch();
        @(posedge clk); #1;
        force_ov = 1'b1;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL mm_err_early: got %b want 0", err); end
        @(posedge clk); #1;
        force_ov = 1'b0;
        @(negedge clk);
        n_vec += 2;
        if (err !== 1'b1) begin n_err++; $display("FAIL mm_err_set: got %b want 1", err); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mm_no_push: got %b want 0", rsp_valid); end
        repeat (5) @(negedge clk);
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL mm_err_sticky: got %b want 1", err); end
        do_reset();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL mm_err_cleared: got %b want 0", err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            randomize_vecs();
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL rand_err: got %b want 0", err); end
    endtask

    initial begin
        randomize_vecs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        test_mismatch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
